// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
// Multi-cycle sequencer for the RV32M multiply/divide group. A start pulse in
// IDLE latches op/operands; PREP takes magnitudes and loads the accumulator,
// CALC runs one shift-add (multiply) or restoring-divide step per cycle, FIX
// applies sign correction and the forced div-by-zero / overflow values, and
// DONE presents the registered result with a one-cycle done pulse.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only in IDLE
//   op     in   M-extension funct3 (MUL..REMU)
//   src_a  in   rs1 (multiplicand / dividend)
//   src_b  in   rs2 (multiplier / divisor)
//   kill   in   synchronous abort of an in-flight op
//   busy   out  high whenever the FSM is not IDLE
//   done   out  one-cycle result-valid pulse
//   result out  registered result, held until the next done
//
// Optional build macro: MULDIV_EARLY_OUT_EN -- divide-by-zero and signed
// overflow skip CALC (PREP -> FIX). Results are identical; only latency differs.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;       // product, or remainder:quotient
    logic [CW-1:0]      cnt_q;
    logic               sign_a_q, sign_b_q, dz_q, ovf_q;
    logic               fix_stage_q; // FIX: 0 = sign correction, 1 = select/override
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   result_q;

    logic               is_div;
    logic               sign_a_d, sign_b_d, dz_d, ovf_d;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_rem_sh, div_trial;
    logic [WIDTH-1:0]   rem_v, quo_v;
    logic [2*WIDTH-1:0] acc_calc_d, acc_fix_d;
    logic [WIDTH-1:0]   result_d;

    always_comb begin
        is_div   = op_q[2];
        sign_a_d = 1'b0;
        sign_b_d = 1'b0;
        case (op_q)
            OP_MULH, OP_DIV, OP_REM: begin
                sign_a_d = a_q[WIDTH-1];
                sign_b_d = b_q[WIDTH-1];
            end
            OP_MULHSU: sign_a_d = a_q[WIDTH-1];
            default: ;
        endcase
        mag_a = sign_a_d ? -a_q : a_q;
        mag_b = sign_b_d ? -b_q : b_q;
        dz_d  = is_div && (b_q == '0);
        ovf_d = is_div && !op_q[0] && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

        // Multiply step: conditional add into upper half, shift right keeping carry.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        // Divide step: the shifted remainder needs WIDTH+1 bits before the trial subtract.
        div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        div_trial  = div_rem_sh - {1'b0, opnd_q};
        if (is_div) begin
            if (div_trial[WIDTH])
                acc_calc_d = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            else
                acc_calc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_calc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end

        // Sign correction: product/quotient by sign_a^sign_b, remainder follows dividend.
        rem_v = acc_q[2*WIDTH-1:WIDTH];
        quo_v = acc_q[WIDTH-1:0];
        if (is_div)
            acc_fix_d = {(sign_a_q ? -rem_v : rem_v), ((sign_a_q ^ sign_b_q) ? -quo_v : quo_v)};
        else
            acc_fix_d = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;

        // Result select; op_q[1] distinguishes REM/REMU from DIV/DIVU.
        if (is_div) begin
            result_d = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
            if (dz_q)
                result_d = op_q[1] ? a_q : '1;
            else if (ovf_q)
                result_d = op_q[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            result_d = (op_q == OP_MUL) ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            cnt_q       <= '0;
            fix_stage_q <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (kill && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !kill) begin
                        op_q    <= op;
                        a_q     <= src_a;
                        b_q     <= src_b;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    sign_a_q    <= sign_a_d;
                    sign_b_q    <= sign_b_d;
                    dz_q        <= dz_d;
                    ovf_q       <= ovf_d;
                    opnd_q      <= is_div ? mag_b : mag_a;
                    acc_q       <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    cnt_q       <= CW'(WIDTH - 1);
                    fix_stage_q <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
                    state_q     <= (dz_d || ovf_d) ? S_FIX : S_CALC;
`else
                    state_q     <= S_CALC;
`endif
                end
                S_CALC: begin
                    acc_q <= acc_calc_d;
                    if (cnt_q == '0)
                        state_q <= S_FIX;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    if (!fix_stage_q) begin
                        acc_q       <= acc_fix_d;
                        fix_stage_q <= 1'b1;
                    end else begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;
    localparam int W        = 32;
    localparam int LAT_FULL = W + 4;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 4;
`else
    localparam int LAT_SPECIAL = W + 4;
`endif

    logic         clk = 1'b0;
    logic         rst, start, kill;
    logic [2:0]   op;
    logic [W-1:0] src_a, src_b, result;
    logic         busy, done;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a),
        .src_b(src_b), .kill(kill), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Issues one op (called 1 time unit after a rising edge, DUT idle) and
    // returns the result, busy-cycle count up to and including the done cycle,
    // whether busy stayed high, and whether the following cycle was idle.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int cycles,
                          output bit busy_ok, output bit idle_ok);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cycles  = 1;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        res = result;
        @(posedge clk); #1;
        idle_ok = (busy === 1'b0) && (done === 1'b0);
        $display("[TB] op=%0d a=%h b=%h result=%h cycles=%0d", o, a, b, res, cycles);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: busy=%b, required 0", busy);
        end
    endtask

    // Vectors: op, a, b, expected, required latency.
    task automatic run_table(input string name, input logic [2:0] ops[], input logic [W-1:0] as[],
                             input logic [W-1:0] bs[], input logic [W-1:0] exps[], input int lat);
        logic [W-1:0] res;
        int cyc;
        bit bok, iok;
        for (int i = 0; i < ops.size(); i++) begin
            run_op(ops[i], as[i], bs[i], res, cyc, bok, iok);
            tests_run++;
            if (res !== exps[i]) begin
                tests_failed++;
                $display("FAIL %s_result[%0d]: got %h, required %h", name, i, res, exps[i]);
            end
            tests_run++;
            if (cyc !== lat || !bok || !iok) begin
                tests_failed++;
                $display("FAIL %s_timing[%0d]: cycles=%0d busy_ok=%b idle_after=%b, required %0d 1 1",
                         name, i, cyc, bok, iok, lat);
            end
        end
    endtask

    task automatic test_mul();
        logic [2:0]   o[] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd1, 3'd1};
        logic [W-1:0] a[] = '{32'h00000007, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000005};
        logic [W-1:0] b[] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD};
        logic [W-1:0] e[] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                              32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        run_table("mul", o, a, b, e, LAT_FULL);
    endtask

    task automatic test_div();
        logic [2:0]   o[] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [W-1:0] a[] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [W-1:0] b[] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [W-1:0] e[] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        run_table("div", o, a, b, e, LAT_FULL);
    endtask

    task automatic test_div_special();
        logic [2:0]   o[] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [W-1:0] a[] = '{32'h80000000, 32'h80000000, 32'd5, 32'd5, 32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [W-1:0] b[] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [W-1:0] e[] = '{32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB};
        run_table("div_special", o, a, b, e, LAT_SPECIAL);
    endtask

    task automatic test_start_while_busy();
        int cyc;
        op = 3'd0; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        // Keep start asserted with different operands through the whole op and its DONE cycle.
        op = 3'd5; src_a = 32'd100; src_b = 32'd3;
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        $display("[TB] start_while_busy result=%h cycles=%0d", result, cyc);
        tests_run++;
        if (result !== 32'd42 || cyc !== LAT_FULL) begin
            tests_failed++;
            $display("FAIL start_while_busy: result=%h cycles=%0d, required 0000002a %0d", result, cyc, LAT_FULL);
        end
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_in_done_ignored: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_kill();
        logic [W-1:0] res;
        int cyc;
        bit bok, iok, saw_done;
        run_op(3'd7, 32'd100, 32'd7, res, cyc, bok, iok);   // leaves result = 2
        tests_run++;
        if (res !== 32'd2) begin
            tests_failed++;
            $display("FAIL kill_setup: got %h, required 00000002", res);
        end
        op = 3'd0; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        $display("[TB] kill mid-calc busy=%b done=%b result=%h", busy, done, result);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd2) begin
            tests_failed++;
            $display("FAIL kill_abort: busy=%b done=%b result=%h, required 0 0 00000002", busy, done, result);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("FAIL kill_no_done: activity seen after kill, required none");
        end
        kill = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b0;
        $display("[TB] kill+start in idle busy=%b", busy);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_start_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_rst_mid();
        logic [W-1:0] res;
        int cyc;
        bit bok, iok;
        op = 3'd5; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("[TB] rst mid-calc busy=%b done=%b result=%h", busy, done, result);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
        run_op(3'd0, 32'd3, 32'd4, res, cyc, bok, iok);
        tests_run++;
        if (res !== 32'd12 || cyc !== LAT_FULL || !bok || !iok) begin
            tests_failed++;
            $display("FAIL rst_then_mul: result=%h cycles=%0d busy_ok=%b idle_after=%b, required 0000000c %0d 1 1",
                     res, cyc, bok, iok, LAT_FULL);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_start_while_busy();
        test_kill();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
